// File: rtl/seq_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier with a start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the signed_op port for two's complement operands.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_op,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_mcand_in;
    logic [WIDTH-1:0]     w_mplier_in;
    logic                 w_neg_in;

    // The core always works on magnitudes; the sign is reapplied when the product is loaded.
`ifdef SEQ_MULT_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    assign w_a_neg     = signed_op & a[WIDTH-1];
    assign w_b_neg     = signed_op & b[WIDTH-1];
    assign w_mcand_in  = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_mplier_in = w_b_neg ? (~b + WIDTH'(1)) : b;
    assign w_neg_in    = w_a_neg ^ w_b_neg;
`else
    assign w_mcand_in  = a;
    assign w_mplier_in = b;
    assign w_neg_in    = 1'b0;
`endif

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_sum    = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    // {carry, acc, mplier} shifted right by one, as it will stand after this RUN step
    assign w_final  = {w_sum, r_mplier[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_mcand   <= w_mcand_in;
            r_mplier  <= w_mplier_in;
            r_acc     <= '0;
            r_neg     <= w_neg_in;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_sum[WIDTH:1];
            r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= r_neg ? (~w_final + (2*WIDTH)'(1)) : w_final;
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=16.
// Signed vectors are added when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           s_in;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op (s_in),
`endif
        .a         (a_in),
        .b         (b_in),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Counts falling edges after the accept edge until done is seen (bounded).
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                          input logic [2*W-1:0] exp, input string name);
        int lat, bcnt;
        @(negedge clk);
        a_in  = va;
        b_in  = vb;
        s_in  = vs;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        check({name, " product"}, product, exp);
        check({name, " latency"}, lat, W + 1);
        check({name, " busy_cycles"}, bcnt, W);
        @(negedge clk);
        check({name, " done_single"}, done, 1'b0);
        repeat (2) @(negedge clk);
        check({name, " product_hold"}, product, exp);
        $display("op %s: a=0x%0h b=0x%0h s=%0d product=0x%0h latency=%0d", name, va, vb, vs, product, lat);
    endtask

    initial begin
        vec_t vecs[$];
        int   lat, bcnt, done_seen;

        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        vecs.push_back('{16'h0000, 16'h1234, 1'b0, 32'h00000000});
        vecs.push_back('{16'h0001, 16'hABCD, 1'b0, 32'h0000ABCD});
        vecs.push_back('{16'h1234, 16'h5678, 1'b0, 32'h06260060});
        vecs.push_back('{16'h8000, 16'h0002, 1'b0, 32'h00010000});
        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 32'h0000000F});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF});
        vecs.push_back('{16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1});
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back('{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
        vecs.push_back('{16'h0007, 16'hFFFF, 1'b1, 32'hFFFFFFF9});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
`endif

        rst_n = 1'b0;
        start = 1'b0;
        s_in  = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset product", product, '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Start pulse and operand changes while busy must not disturb the running operation.
        @(negedge clk);
        a_in = 16'h0003; b_in = 16'h0005; s_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                a_in = 16'h0007; b_in = 16'h0009; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        check("busy_ignore product", product, 32'h0000000F);
        check("busy_ignore latency", lat, W + 1);
        @(negedge clk);
        check("busy_ignore idle", busy, 1'b0);
        $display("op busy_ignore: product=0x%0h latency=%0d", product, lat);

        // Back-to-back: start held high, second operation accepted only in the DONE cycle.
        @(negedge clk);
        a_in = 16'h0003; b_in = 16'h0004; start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                a_in = 16'h0010; b_in = 16'h0020;
            end
            if (done) break;
        end
        check("b2b first product", product, 32'h0000000C);
        check("b2b first latency", lat, W + 1);
        $display("op b2b_first: product=0x%0h latency=%0d", product, lat);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bcnt);
        check("b2b second product", product, 32'h00000200);
        check("b2b second latency", lat, W + 1);
        check("b2b second busy_cycles", bcnt, W);
        $display("op b2b_second: product=0x%0h latency=%0d", product, lat);

        // Reset at cnt=7 aborts the operation with no done pulse.
        @(negedge clk);
        a_in = 16'h1234; b_in = 16'h5678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort product", product, '0);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort quiet", done_seen, 0);
        $display("op abort: product=0x%0h", product);
        run_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, multi-cycle radix-2 shift-add multiplier. It is the successor to the 16-bit single-cycle combinational multiplier in the calculator datapath.
- It trades latency for area: there is one adder of WIDTH+1 bits instead of a full array.
- It uses a start/busy/done handshake so the calculator control FSM can sequence MUL operations.
- The product is held stable in a register until the next accepted operation completes.

Parameters:
- WIDTH, 16, operand width in bits. Legal range is 2..64. The product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a multiply. Sampled on the rising edge of clk.
- a  input  WIDTH  multiplicand. Captured when start is accepted.
- b  input  WIDTH  multiplier. Captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  result register. Holds its value until the next done.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, product=0.
  - Internal accumulator, operand registers and counter are cleared.
  - Reset mid-operation aborts the operation. No done pulse is produced and product reads 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch a into mcand and b into mplier, clear acc and cnt, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If mplier[0]=1, acc_hi = acc_hi + mcand, with the carry captured.
  - Shift {carry, acc, mplier} right by 1.
  - cnt increments.
  - When cnt == WIDTH-1, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE (one cycle):
  - done=1, and product is loaded with the final accumulator on entry, so it is visible in the same cycle done is high.
  - If start=1 in DONE, the operation is accepted exactly as in IDLE (back-to-back) and the next state is RUN.
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge T0 means busy=1 from T0 through T0+WIDTH-1, and done=1 with product valid in the cycle after edge T0+WIDTH. This is WIDTH+1 cycles from start to done.
- busy = (state == RUN). done = (state == DONE). Both are registered, glitch-free decodes.
- start while busy=1 is ignored. Operands already latched are unaffected, and a and b may change freely during RUN.
- Arithmetic is unsigned and exact, with no truncation. The maximum result is (2^WIDTH-1)^2, which fits in 2*WIDTH bits.
- product changes only at reset or on entry to DONE.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), captured with a and b at start.
  - If signed_op=1, a and b are two's complement. The core multiplies the magnitudes, and the product is negated in DONE if the signs differ.
  - The result is the exact 2*WIDTH-bit two's complement value, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
  - Latency is unchanged.
  - If signed_op=0, behaviour is identical to the unsigned mode.
- Undefined: the port is absent and all operations are unsigned.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0xFFFF, start pulse at T0 -> busy high for 16 cycles; done pulses once at T0+17; product=0xFFFE0001.
- a=0x0000, b=0x1234, then a=0x0001, b=0xABCD -> product=0x00000000, then 0x0000ABCD; product stays stable between done pulses.
- start asserted continuously with the operands changed mid-RUN -> second operation accepted only in the DONE cycle (back-to-back); each result matches the operands latched at its accept edge; no start is accepted while busy=1.
- rst_n=0 for 1 cycle at cnt=7 of a 0x1234*0x5678 operation -> busy=0, done never pulses, product=0; a subsequent 0x1234*0x5678 gives 0x06260060.
- Random sweep with WIDTH=8 and WIDTH=32, 1000 operations each -> product equals the reference a*b; latency is always WIDTH+1 cycles.
- SEQ_MULT_SIGNED_EN defined, WIDTH=16:
  - signed_op=1, a=0xFFFD (-3), b=0x0005 -> product=0xFFFFFFF1.
  - signed_op=1, a=b=0x8000 -> product=0x40000000.
  - signed_op=0, a=0xFFFD, b=0x0005 -> product=0x0004FFF1.
